// File: rtl/token_writer.sv
// Token writer: ORs, clears or tests a 4-wide shape against board rows through
// a read-modify-write port and reports overlap, overflow and off-board rows.
module token_writer #(
  parameter int COLS   = 10,
  parameter int ROWS   = 32,
  parameter int ADDR_W = 5,
  parameter int TOK_H  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        tok_id,
  input  logic [ADDR_W-1:0] base_row,
  input  logic [3:0]        col_shift,
  input  logic [1:0]        mode,
  input  logic [COLS-1:0]   rd_data,
  output logic [ADDR_W-1:0] address,
  output logic [COLS-1:0]   wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic              collision
);

  localparam int PW = COLS + 4;

  typedef enum logic [2:0] {IDLE, RD, MRG, WR, DONE} state_t;

  state_t            state, stateNext;
  logic [1:0]        tokReg;
  logic [1:0]        modeReg;
  logic [ADDR_W-1:0] baseReg;
  logic [3:0]        shiftReg;
  logic [1:0]        rowIdx;
  logic [COLS-1:0]   rowData;

  logic [3:0]        shapeBits;
  logic [PW-1:0]     placed;
  logic [ADDR_W:0]   rowAddr;
  logic              rowInRange;
  logic              lastRow;
  logic              overlap;
  logic              overflow;

  function automatic logic [3:0] shapeRow(input logic [1:0] id, input logic [1:0] r);
    logic [3:0] bits;
    bits = 4'b0000;
    case ({id, r})
      4'b00_00, 4'b00_01: bits = 4'b0011;
      4'b01_00, 4'b01_01: bits = 4'b0001;
      4'b01_10:           bits = 4'b0011;
      4'b10_00:           bits = 4'b0111;
      4'b10_01:           bits = 4'b0010;
      4'b11_00, 4'b11_01,
      4'b11_10, 4'b11_11: bits = 4'b0001;
      default:            bits = 4'b0000;
    endcase
    return bits;
  endfunction

  // Row address carries one extra bit so rows past the board are detected, not wrapped.
  assign shapeBits  = shapeRow(tokReg, rowIdx);
  assign placed     = {{COLS{1'b0}}, shapeBits} << shiftReg;
  assign rowAddr    = {1'b0, baseReg} + {{(ADDR_W-1){1'b0}}, rowIdx};
  assign rowInRange = (32'(rowAddr) < 32'(ROWS));
  assign lastRow    = (rowIdx == 2'(TOK_H - 1));
  assign overlap    = ((placed[COLS-1:0] & rd_data) != '0);
  assign overflow   = (placed[PW-1:COLS] != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tokReg    <= '0;
      modeReg   <= '0;
      baseReg   <= '0;
      shiftReg  <= '0;
      rowIdx    <= '0;
      rowData   <= '0;
      collision <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tokReg    <= tok_id;
            modeReg   <= mode;
            baseReg   <= base_row;
            shiftReg  <= col_shift;
            rowIdx    <= '0;
            collision <= 1'b0;
          end
        end
        MRG: begin
          rowData <= rd_data;
          // Off-board rows have no meaningful read data; only a nonzero shape row counts.
          if (rowInRange) begin
            if (overlap || overflow) collision <= 1'b1;
          end else if (shapeBits != 4'b0000) begin
            collision <= 1'b1;
          end
        end
        WR: begin
          if (!lastRow) rowIdx <= rowIdx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext = state;
    address   = '0;
    wr_data   = '0;
    wr_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) stateNext = RD;
      end
      RD: begin
        busy      = 1'b1;
        address   = rowAddr[ADDR_W-1:0];
        stateNext = MRG;
      end
      MRG: begin
        busy      = 1'b1;
        address   = rowAddr[ADDR_W-1:0];
        stateNext = WR;
      end
      WR: begin
        busy    = 1'b1;
        address = rowAddr[ADDR_W-1:0];
        case (modeReg)
          2'b00: begin
            wr_data = rowData | placed[COLS-1:0];
            wr_en   = rowInRange;
          end
          2'b01: begin
            wr_data = rowData & ~placed[COLS-1:0];
            wr_en   = rowInRange;
          end
          default: wr_data = rowData;
        endcase
        stateNext = lastRow ? DONE : RD;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_token_writer.sv
// Bench for token_writer: a behavioural board RAM, a queue of expected row
// writes and directed operations checking timing, flags and reset behaviour.
module tb_token_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] tok_id;
  logic [4:0] base_row;
  logic [3:0] col_shift;
  logic [1:0] mode;
  logic [9:0] rd_data;
  logic [4:0] address;
  logic [9:0] wr_data;
  logic       wr_en;
  logic       busy;
  logic       done;
  logic       collision;

  int assertCount = 0;
  int failCount   = 0;

  logic [9:0] board [0:31];
  logic       clearEn;
  logic       loadEn;
  logic [4:0] loadAddr;
  logic [9:0] loadVal;

  typedef struct packed {
    logic [4:0] addr;
    logic [9:0] data;
  } wr_t;
  wr_t expQ[$];

  token_writer #(.COLS(10), .ROWS(32), .ADDR_W(5), .TOK_H(4)) dut (
    .clk(clk), .reset(reset), .start(start), .tok_id(tok_id),
    .base_row(base_row), .col_shift(col_shift), .mode(mode),
    .rd_data(rd_data), .address(address), .wr_data(wr_data),
    .wr_en(wr_en), .busy(busy), .done(done), .collision(collision)
  );

  always #5 clk = ~clk;

  // Board RAM: one-cycle read latency, write on wr_en, plus bench-side clear/preload.
  always @(posedge clk) begin
    rd_data <= board[address];
    if (clearEn) begin
      for (int i = 0; i < 32; i++) board[i] <= '0;
    end else if (loadEn) begin
      board[loadAddr] <= loadVal;
    end else if (wr_en) begin
      board[address] <= wr_data;
    end
  end

  always @(negedge clk) begin : writeMonitor
    wr_t exp;
    if (wr_en) begin
      assertCount++;
      assert (expQ.size() != 0) else begin
        failCount++;
        $error("FAIL unexpected_wr observed addr=%0d data=%h expected no write", address, wr_data);
      end
      if (expQ.size() != 0) begin
        exp = expQ.pop_front();
        assertCount++;
        assert ({address, wr_data} === exp) else begin
          failCount++;
          $error("FAIL wr_row observed addr=%0d data=%h expected addr=%0d data=%h",
                 address, wr_data, exp.addr, exp.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushWr(input logic [4:0] a, input logic [9:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    expQ.push_back(w);
  endtask

  task automatic clearBoard();
    @(negedge clk); clearEn = 1'b1;
    @(negedge clk); clearEn = 1'b0;
  endtask

  task automatic loadRow(input logic [4:0] a, input logic [9:0] v);
    @(negedge clk); loadEn = 1'b1; loadAddr = a; loadVal = v;
    @(negedge clk); loadEn = 1'b0;
  endtask

  // One operation: start sampled at T0, done expected in cycle T0+13.
  task automatic applyStimulus(input string tag, input logic [1:0] id, input logic [4:0] base,
                               input logic [3:0] shift, input logic [1:0] md,
                               input logic expColl, input bit holdStart);
    int k;
    @(negedge clk);
    tok_id = id; base_row = base; col_shift = shift; mode = md; start = 1'b1;
    @(negedge clk);
    k = 1;
    if (holdStart) begin
      tok_id = ~id; base_row = base + 5'd3; col_shift = shift + 4'd1; mode = ~md;
    end else begin
      start = 1'b0;
    end
    checkOutput({tag, "_busy_running"}, busy, 1'b1);
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_latency"}, k, 13);
    checkOutput({tag, "_busy_at_done"}, busy, 1'b0);
    checkOutput({tag, "_collision"}, collision, expColl);
    start = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_done_one_cycle"}, done, 1'b0);
    checkOutput({tag, "_collision_held"}, collision, expColl);
    checkOutput({tag, "_writes_drained"}, expQ.size(), 0);
  endtask

  initial begin
    $display("[TB] token_writer bench starting");
    reset = 1'b1; start = 1'b0; tok_id = '0; base_row = '0; col_shift = '0; mode = '0;
    clearEn = 1'b0; loadEn = 1'b0; loadAddr = '0; loadVal = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_wr_en", wr_en, 1'b0);
    checkOutput("reset_address", address, 0);
    checkOutput("reset_wr_data", wr_data, 0);
    checkOutput("reset_collision", collision, 1'b0);
    reset = 1'b0;
    clearBoard();

    // Place id0 at shift 4 on an empty board.
    pushWr(5'd0, 10'h030); pushWr(5'd1, 10'h030); pushWr(5'd2, 10'h000); pushWr(5'd3, 10'h000);
    applyStimulus("place_id0", 2'd0, 5'd0, 4'd4, 2'b00, 1'b0, 1'b0);

    // Erase id0 from a full row 1.
    clearBoard();
    loadRow(5'd1, 10'h3FF);
    pushWr(5'd0, 10'h000); pushWr(5'd1, 10'h3FC); pushWr(5'd2, 10'h000); pushWr(5'd3, 10'h000);
    applyStimulus("erase_overlap", 2'd0, 5'd0, 4'd0, 2'b01, 1'b1, 1'b0);

    // Check-only with overflow past column 9: no writes expected.
    clearBoard();
    applyStimulus("check_overflow", 2'd2, 5'd5, 4'd9, 2'b10, 1'b1, 1'b0);

    // Rows 32 and 33 fall off the board.
    clearBoard();
    pushWr(5'd30, 10'h001); pushWr(5'd31, 10'h001);
    applyStimulus("offboard_rows", 2'd3, 5'd30, 4'd0, 2'b00, 1'b1, 1'b0);

    // Mode 11 behaves as check-only and still flags overlap.
    clearBoard();
    loadRow(5'd7, 10'h020);
    applyStimulus("mode3_overlap", 2'd0, 5'd6, 4'd4, 2'b11, 1'b1, 1'b0);

    // Shift 7 puts id2 flush against the top column without overflow.
    clearBoard();
    loadRow(5'd15, 10'h001);
    pushWr(5'd15, 10'h381); pushWr(5'd16, 10'h100); pushWr(5'd17, 10'h000); pushWr(5'd18, 10'h000);
    applyStimulus("place_edge", 2'd2, 5'd15, 4'd7, 2'b00, 1'b0, 1'b0);

    // Reset two cycles after start: operation must vanish silently.
    clearBoard();
    @(negedge clk);
    tok_id = 2'd0; base_row = 5'd0; col_shift = 4'd4; mode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midreset_busy", busy, 1'b0);
    checkOutput("midreset_collision", collision, 1'b0);
    checkOutput("midreset_address", address, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("midreset_no_done", done, 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checkOutput("postreset_idle_done", done, 1'b0);
    end
    checkOutput("postreset_busy", busy, 1'b0);

    // Start held high with inputs changing mid-operation: exactly one operation.
    pushWr(5'd10, 10'h004); pushWr(5'd11, 10'h004); pushWr(5'd12, 10'h00C); pushWr(5'd13, 10'h000);
    applyStimulus("held_start", 2'd1, 5'd10, 4'd2, 2'b00, 1'b0, 1'b1);
    repeat (15) @(negedge clk);
    checkOutput("held_start_idle_after", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
